// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the 8-bit CPU: walks each opcode through its control
// states, stalls on memory, resolves conditional jumps, holds in HALT, flags bad opcodes.
module cpu_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int STATE_W  = 4,
    parameter int CYCLE_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    input  logic                resume,
    output logic [STATE_W-1:0]  state,
    output logic [CYCLE_W-1:0]  cycle,
    output logic                inst_done,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [3:0] {
        FETCH_PC   = 4'd0,
        FETCH_INST = 4'd1,
        HALT       = 4'd2,
        JUMP       = 4'd3,
        OUT_A      = 4'd4,
        NEXT       = 4'd5,
        LOAD_ADDR  = 4'd6,
        RAM_A      = 4'd7,
        RAM_B      = 4'd8,
        ALU_OP     = 4'd9,
        STORE_A    = 4'd10
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JEZ = 4'd7;
    localparam logic [3:0] OP_JNZ = 4'd8;
    localparam logic [3:0] OP_HLT = 4'd15;

    state_t               state_q, state_d;
    logic [CYCLE_W-1:0]   cycle_q, cycle_d;
    logic [3:0]           op_q, op_d;
    logic                 illegal_q, illegal_d;
    logic [3:0]           op_lo;
    logic [3:0]           op_eff;
    logic                 op_legal;
    logic                 advance;

    // Illegal opcodes are latched as NOP so the rest of the machine never sees them.
    assign op_lo    = opcode[3:0];
    assign op_legal = ((opcode >> 4) == '0) && ((op_lo <= OP_JNZ) || (op_lo == OP_HLT));
    assign op_eff   = op_legal ? op_lo : OP_NOP;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        advance   = 1'b0;
        unique case (state_q)
            FETCH_PC: begin
                advance = 1'b1;
                if (cycle_q == '0) begin
                    state_d = FETCH_INST;
                end else begin
                    case (op_q)
                        OP_JMP:  state_d = JUMP;
                        OP_JEZ:  state_d = zero_flag ? JUMP : NEXT;
                        OP_JNZ:  state_d = zero_flag ? NEXT : JUMP;
                        OP_LDA, OP_STA, 4'd2, 4'd3: state_d = LOAD_ADDR;
                        default: state_d = NEXT;
                    endcase
                end
            end
            FETCH_INST: begin
                if (mem_ready) begin
                    advance   = 1'b1;
                    op_d      = op_eff;
                    illegal_d = illegal_q | ~op_legal;
                    case (op_eff)
                        OP_NOP:  state_d = NEXT;
                        OP_OUT:  state_d = OUT_A;
                        OP_HLT:  state_d = HALT;
                        default: state_d = FETCH_PC;
                    endcase
                end
            end
            LOAD_ADDR: begin
                if (mem_ready) begin
                    advance = 1'b1;
                    case (op_q)
                        OP_LDA:  state_d = RAM_A;
                        OP_STA:  state_d = STORE_A;
                        default: state_d = RAM_B;
                    endcase
                end
            end
            RAM_A, STORE_A: begin
                if (mem_ready) begin
                    advance = 1'b1;
                    state_d = NEXT;
                end
            end
            RAM_B: begin
                if (mem_ready) begin
                    advance = 1'b1;
                    state_d = ALU_OP;
                end
            end
            HALT: begin
                if (resume) begin
                    advance = 1'b1;
                    state_d = NEXT;
                end
            end
            ALU_OP, OUT_A, JUMP, NEXT: begin
                advance = 1'b1;
                state_d = (state_q == NEXT) ? FETCH_PC : NEXT;
            end
            default: begin
                state_d = FETCH_PC;
            end
        endcase
    end

    // The micro-cycle counter restarts only when a new instruction begins.
    always_comb begin
        cycle_d = cycle_q;
        if (advance) begin
            cycle_d = (state_q == NEXT) ? '0 : cycle_q + CYCLE_W'(1);
        end else if (state_d == FETCH_PC) begin
            cycle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH_PC;
            cycle_q   <= '0;
            op_q      <= OP_NOP;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign state     = STATE_W'(state_q);
    assign cycle     = cycle_q;
    assign inst_done = (state_q == NEXT);
    assign halted    = (state_q == HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: latency table, directed corner sequences,
// and randomized instructions checked against a per-opcode state-list model.
module tb_cpu_sequencer;

    localparam int S_FETCH_PC = 0, S_FETCH_INST = 1, S_HALT = 2, S_JUMP = 3, S_OUT_A = 4;
    localparam int S_NEXT = 5, S_LOAD_ADDR = 6, S_RAM_A = 7, S_RAM_B = 8, S_ALU_OP = 9;
    localparam int S_STORE_A = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       mem_ready;
    logic       resume;
    logic [3:0] state;
    logic [2:0] cycle;
    logic       inst_done;
    logic       halted;
    logic       illegal;

    int vec_count   = 0;
    int miscompares = 0;
    bit exp_illegal = 1'b0;
    int seq[16];
    int seq_len;

    typedef struct {
        logic [3:0] op;
        bit         zf;
        int         lat;
        bit         ill;
    } vec_t;
    vec_t vecs[14];

    int nop_st[4] = '{0, 1, 5, 0};
    int nop_cy[4] = '{0, 1, 2, 0};
    int add_st[9] = '{0, 1, 0, 6, 8, 8, 8, 9, 5};
    int add_cy[9] = '{0, 1, 2, 3, 4, 4, 4, 5, 6};
    bit add_mr[9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};

    cpu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .mem_ready (mem_ready),
        .resume    (resume),
        .state     (state),
        .cycle     (cycle),
        .inst_done (inst_done),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_state(input string tag, input int st, input int cy);
        check_output({tag, " state"}, 32'(state), st);
        check_output({tag, " cycle"}, 32'(cycle), cy);
        check_output({tag, " inst_done"}, 32'(inst_done), 32'(st == S_NEXT));
        check_output({tag, " halted"}, 32'(halted), 32'(st == S_HALT));
        check_output({tag, " illegal"}, 32'(illegal), 32'(exp_illegal));
    endtask

    function automatic bit is_illegal_op(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

    function automatic bit is_mem_state(input int st);
        return st == S_FETCH_INST || st == S_LOAD_ADDR || st == S_RAM_A ||
               st == S_RAM_B || st == S_STORE_A;
    endfunction

    task automatic add_step(input int st);
        seq[seq_len] = st;
        seq_len++;
    endtask

    // Reference: the state list each opcode walks through, with no stalls.
    task automatic build_seq(input logic [3:0] op, input bit zf);
        seq_len = 0;
        add_step(S_FETCH_PC);
        add_step(S_FETCH_INST);
        case (op)
            4'd5:  begin add_step(S_OUT_A); end
            4'd15: begin add_step(S_HALT); end
            4'd6:  begin add_step(S_FETCH_PC); add_step(S_JUMP); end
            4'd7:  begin add_step(S_FETCH_PC); if (zf) add_step(S_JUMP); end
            4'd8:  begin add_step(S_FETCH_PC); if (!zf) add_step(S_JUMP); end
            4'd1:  begin add_step(S_FETCH_PC); add_step(S_LOAD_ADDR); add_step(S_RAM_A); end
            4'd4:  begin add_step(S_FETCH_PC); add_step(S_LOAD_ADDR); add_step(S_STORE_A); end
            4'd2, 4'd3: begin
                add_step(S_FETCH_PC); add_step(S_LOAD_ADDR); add_step(S_RAM_B); add_step(S_ALU_OP);
            end
            default: ;
        endcase
        add_step(S_NEXT);
    endtask

    // Called at a negedge where an instruction is about to start in FETCH_PC.
    task automatic run_instr(input logic [3:0] op, input bit zf, input int stall_pct, input string tag);
        int idx = 0;
        int budget = 0;
        bit adv;
        build_seq(op, zf);
        while (idx < seq_len) begin
            expect_state(tag, seq[idx], idx);
            opcode    = (idx == 1) ? op : 4'($urandom);
            zero_flag = (idx == 2) ? zf : 1'($urandom);
            mem_ready = ($urandom_range(99) >= stall_pct);
            resume    = ($urandom_range(99) >= stall_pct);
            if (is_mem_state(seq[idx]))      adv = mem_ready;
            else if (seq[idx] == S_HALT)     adv = resume;
            else                             adv = 1'b1;
            if (adv && idx == 1 && is_illegal_op(op)) exp_illegal = 1'b1;
            if (adv) idx++;
            @(negedge clk);
            budget++;
            if (budget > 300) begin
                vec_count++;
                miscompares++;
                $display("[TB] FAIL %s timeout: got %0d cycles, expected at most 300", tag, budget);
                break;
            end
        end
        mem_ready = 1'b1;
        resume    = 1'b0;
    endtask

    task automatic run_partial(input logic [3:0] op, input int steps, input string tag);
        build_seq(op, 1'b0);
        mem_ready = 1'b1;
        resume    = 1'b1;
        for (int i = 0; i < steps; i++) begin
            expect_state(tag, seq[i], i);
            opcode = (i == 1) ? op : 4'($urandom);
            @(negedge clk);
        end
        expect_state(tag, seq[steps], steps);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        exp_illegal = 1'b0;
        expect_state(tag, S_FETCH_PC, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Asserts reset between edges and checks that the outputs drop without a clock.
    task automatic async_abort(input string tag);
        #2 reset = 1'b0;
        #1;
        exp_illegal = 1'b0;
        expect_state({tag, " async"}, S_FETCH_PC, 0);
        @(negedge clk);
        expect_state({tag, " held"}, S_FETCH_PC, 0);
        reset     = 1'b1;
        mem_ready = 1'b1;
        resume    = 1'b0;
        run_instr(4'd0, 1'b0, 0, {tag, " restart"});
    endtask

    task automatic apply_stimulus();
        int done_cnt;
        int lat;

        reset = 1'b0; opcode = 4'd0; zero_flag = 1'b0; mem_ready = 1'b1; resume = 1'b0;
        @(negedge clk);
        expect_state("reset", S_FETCH_PC, 0);
        reset = 1'b1;

        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            expect_state("nop", nop_st[i], nop_cy[i]);
            done_cnt += int'(inst_done);
            if (i < 3) @(negedge clk);
        end
        check_output("nop inst_done width", done_cnt, 1);

        for (int i = 0; i < 9; i++) begin
            expect_state("add stall", add_st[i], add_cy[i]);
            opcode    = (i <= 1) ? 4'd2 : 4'($urandom);
            mem_ready = add_mr[i];
            @(negedge clk);
        end
        mem_ready = 1'b1;
        expect_state("add stall end", S_FETCH_PC, 0);

        run_instr(4'd7, 1'b1, 0, "jez taken");
        run_instr(4'd7, 1'b0, 0, "jez skip");
        run_instr(4'd8, 1'b0, 0, "jnz taken");
        run_instr(4'd8, 1'b1, 0, "jnz skip");

        opcode = 4'd15; resume = 1'b0;
        expect_state("hlt", S_FETCH_PC, 0);
        @(negedge clk);
        expect_state("hlt", S_FETCH_INST, 1);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            expect_state("hlt hold", S_HALT, 2);
            resume = (k == 9);
            @(negedge clk);
        end
        resume = 1'b0;
        expect_state("hlt resume", S_NEXT, 3);
        @(negedge clk);
        expect_state("hlt after", S_FETCH_PC, 0);

        run_instr(4'd12, 1'b0, 0, "illegal 12");
        for (int k = 0; k < 3; k++) run_instr(4'd1, 1'b0, 30, "lda sticky");

        run_partial(4'd2, 5, "abort alu");
        async_abort("abort alu");
        run_partial(4'd15, 2, "abort halt");
        resume = 1'b0;
        @(negedge clk);
        expect_state("abort halt hold", S_HALT, 2);
        async_abort("abort halt");
        run_partial(4'd1, 4, "abort stall");
        mem_ready = 1'b0;
        @(negedge clk);
        expect_state("abort stall hold", S_RAM_A, 4);
        async_abort("abort stall");

        vecs = '{
            '{4'd0,  1'b0, 3, 1'b0}, '{4'd1,  1'b0, 6, 1'b0}, '{4'd2,  1'b0, 7, 1'b0},
            '{4'd3,  1'b1, 7, 1'b0}, '{4'd4,  1'b0, 6, 1'b0}, '{4'd5,  1'b0, 4, 1'b0},
            '{4'd6,  1'b0, 5, 1'b0}, '{4'd7,  1'b1, 5, 1'b0}, '{4'd7,  1'b0, 4, 1'b0},
            '{4'd8,  1'b0, 5, 1'b0}, '{4'd8,  1'b1, 4, 1'b0}, '{4'd15, 1'b0, 4, 1'b0},
            '{4'd9,  1'b0, 3, 1'b1}, '{4'd14, 1'b1, 3, 1'b1}
        };
        foreach (vecs[v]) begin
            opcode = vecs[v].op; zero_flag = vecs[v].zf; mem_ready = 1'b1; resume = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!(state == 4'd0 && cycle == 3'd0) && lat < 40);
            check_output($sformatf("latency op%0d zf%0d", vecs[v].op, vecs[v].zf), lat, vecs[v].lat);
            check_output($sformatf("illegal op%0d", vecs[v].op), 32'(illegal), 32'(vecs[v].ill));
        end
        resume = 1'b0;

        apply_reset("reset before random");
        for (int n = 0; n < 80; n++) begin
            run_instr(4'($urandom_range(15)), 1'($urandom), $urandom_range(40), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        apply_stimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised instruction sequencer for the 8-bit CPU. It replaces the externally counted, purely decoded control step with a self-contained machine. It owns the micro-cycle counter and the latched opcode, and ends each instruction as soon as its last useful step is done instead of padding to a fixed length. It stalls on memory, resolves conditional jumps against the zero flag, holds in HALT until resumed, and flags illegal opcodes. It sits between the instruction register/flags and the datapath control-word decoder, which consumes `state`.

## Interface
- `OPCODE_W`, default 4: width of `opcode`. Any opcode with a bit set above bit 3 is illegal.
- `STATE_W`, default 4: width of `state`. Must be at least 4.
- `CYCLE_W`, default 3: width of `cycle`. Must be at least 3.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `opcode`  in  OPCODE_W: instruction register output, valid during FETCH_INST.
- `zero_flag`  in  1: ALU zero flag.
- `mem_ready`  in  1: memory access completes this cycle.
- `resume`  in  1: leave HALT.
- `state`  out  STATE_W: current control state (registered).
- `cycle`  out  CYCLE_W: micro-cycle within the instruction (registered).
- `inst_done`  out  1: high while `state`==NEXT.
- `halted`  out  1: high while `state`==HALT.
- `illegal`  out  1: sticky illegal-opcode flag, cleared only by reset.

## Operation
- State encodings: FETCH_PC=0, FETCH_INST=1, HALT=2, JUMP=3, OUT_A=4, NEXT=5, LOAD_ADDR=6, RAM_A=7, RAM_B=8, ALU_OP=9, STORE_A=10. Values are zero-extended to STATE_W.
- Opcode encodings: NOP=0, LDA=1, ADD=2, SUB=3, STA=4, OUT=5, JMP=6, JEZ=7, JNZ=8, HLT=15. Opcodes 9–14 and any wider value are illegal and execute as NOP.
- Opcode register: captured from `opcode` on the clock edge that leaves FETCH_INST. Later changes on `opcode` are ignored until the next FETCH_INST.
- Every instruction starts FETCH_PC (cycle 0) -> FETCH_INST (cycle 1). The remaining sequence depends on the opcode:
  - NOP/illegal: NEXT.
  - OUT: OUT_A -> NEXT.
  - HLT: HALT -> NEXT.
  - JMP: FETCH_PC -> JUMP -> NEXT.
  - JEZ/JNZ: FETCH_PC -> JUMP -> NEXT if the condition is true. If false, FETCH_PC -> NEXT (operand skipped, no JUMP).
  - LDA: FETCH_PC -> LOAD_ADDR -> RAM_A -> NEXT.
  - STA: FETCH_PC -> LOAD_ADDR -> STORE_A -> NEXT.
  - ADD/SUB: FETCH_PC -> LOAD_ADDR -> RAM_B -> ALU_OP -> NEXT.
- NEXT always goes to FETCH_PC with cycle 0.
- `cycle` increments by 1 on every advancing edge and resets to 0 with FETCH_PC. The maximum value is 6 (ADD/SUB NEXT); it never wraps.
- Memory states are FETCH_INST, LOAD_ADDR, RAM_A, RAM_B and STORE_A. In these states, `mem_ready`=0 holds both `state` and `cycle`. The machine advances on the first edge where `mem_ready`=1. `mem_ready` is ignored in all other states.
- HALT holds while `resume`=0. On an edge with `resume`=1 it advances to NEXT. If `resume` is already 1 on HALT entry, HALT still lasts at least one cycle.
- Condition evaluation: `zero_flag` is sampled on the edge leaving the cycle-2 FETCH_PC of JEZ/JNZ. JEZ is taken if the flag is 1; JNZ is taken if it is 0.
- `illegal` is set on the edge that captures an illegal opcode.

## Timing
- Reset (asynchronous assert, synchronous release behaviour on the next edge):
  - `state`=FETCH_PC, `cycle`=0.
  - Opcode register = 0.
  - `illegal`=0, `inst_done`=0, `halted`=0.
  - First FETCH_INST occurs at the first edge after reset deasserts.
- Instruction latency in cycles with no stalls: NOP 3, OUT 4, HLT 4 (with immediate resume), JMP 5, JEZ/JNZ taken 5, JEZ/JNZ not taken 4, LDA 6, STA 6, ADD/SUB 7.
- Each stall cycle adds exactly one cycle of latency.
- `inst_done` and `halted` are decoded from registered `state` only, so they are glitch-free and not driven by inputs.
- Reset asserted mid-instruction, in HALT, or during a stall aborts immediately to the reset values. No partial instruction resumes afterwards.
- `resume` and `mem_ready` asserted in the same cycle: only the input relevant to the current state has any effect.

## Test plan
- Reset then NOP (`opcode`=0, `mem_ready`=1): `state` sequence 0,1,5,0 with `cycle` 0,1,2,0. `inst_done` is high for exactly one cycle.
- ADD (`opcode`=2) with `mem_ready` low for 2 cycles in RAM_B: sequence 0,1,0,6,8,8,8,9,5. `cycle` holds at 4 during the stall. Total 9 cycles.
- JEZ (`opcode`=7): with `zero_flag`=1 the sequence is 0,1,0,3,5. With `zero_flag`=0 it is 0,1,0,5. Repeat for JNZ with the flag values inverted.
- HLT (`opcode`=15) with `resume` held low for 10 cycles: `state`=2 and `halted`=1 throughout. `resume` pulse -> NEXT on the next edge, then FETCH_PC.
- Illegal `opcode`=12: executes as NOP (0,1,5) and `illegal` goes high and stays high through following LDA instructions. Only reset clears it.
- Assert `reset` low asynchronously mid-ALU_OP (between edges): outputs go to reset values immediately. After release, a normal fetch starts at cycle 0.
